cfg_frame_loader: RTL and testbench
===================================

# cfg_frame_loader

Serial-to-parallel configuration loader that drives the `config_en` / `config_in` load port of the CLB LUT tiles. It accepts a framed bitstream one bit per handshake and deserializes an addressed payload. It then issues a single-cycle load strobe to exactly one target tile. One instance sits at the head of a column of fracturable LUT slices, with `config_in` fanned out to all slices and `config_en` one-hot per slice.

## Interface
Parameters:
- `INPUTS`, 4, LUT input count of the targets.
- `CFG_WIDTH`, 2*2**INPUTS+1, payload width. The MSB is the fracture/split bit.
- `NUM_TARGETS`, 8, number of tiles addressed (≥2).
- `IDX_W`, $clog2(NUM_TARGETS), width of the target index field.
- `COUNT_W`, 8, width of the committed-frame counter.

Ports:
- `config_clk`  in  1  sole clock, rising edge.
- `config_rst_n`  in  1  reset, synchronous, active-low.
- `bs_data`  in  1  bitstream bit.
- `bs_valid`  in  1  `bs_data` is valid this cycle.
- `bs_ready`  out  1  loader accepts a bit this cycle.
- `config_in`  out  CFG_WIDTH  payload bus to all targets.
- `config_en`  out  NUM_TARGETS  one-hot load strobe, one bit per target.
- `busy`  out  1  frame in progress, i.e. state ≠ IDLE.
- `err`  out  1  sticky frame error.
- `frame_count`  out  COUNT_W  number of successfully committed frames.

## Operation
- A bit is accepted on a rising edge when `bs_valid && bs_ready`. No state changes on any edge without an accepted bit, except when leaving COMMIT.
- Frame format, MSB first: start bit `1`, then IDX_W index bits, then CFG_WIDTH payload bits, then a parity bit only if `CFG_PARITY_EN` is defined.
- State machine:
  - IDLE: an accepted `0` is idle fill and is ignored. An accepted `1` moves to INDEX.
  - INDEX: shifts in IDX_W bits. Moves to PAYLOAD after the last one.
  - PAYLOAD: shifts CFG_WIDTH bits into an internal shift register. The first payload bit ends at bit CFG_WIDTH-1. After the last bit, moves to PARITY if enabled, otherwise to COMMIT.
  - PARITY: accepts one bit, then moves to COMMIT.
  - COMMIT: lasts exactly one cycle, then moves to IDLE.
- During the COMMIT cycle, with a valid frame:
  - `config_in` equals the shift register.
  - `config_en[idx]` = 1 and all other `config_en` bits = 0.
  - `frame_count` increments at the end of the cycle and wraps modulo 2**COUNT_W.
- During the COMMIT cycle, with an invalid frame:
  - Invalid means `idx ≥ NUM_TARGETS` or parity mismatch.
  - `config_en` stays all-zero, `config_in` is not updated and `frame_count` is unchanged.
  - `err` is set to 1 and stays 1 until reset.
- `config_in` holds its last committed value between commits. The shift register never drives `config_in` directly.
- `bs_ready` = 0 only in COMMIT and is 1 in all other states. It is decoded from the state register.
- Reset mid-frame discards the partial frame. No strobe is issued.

## Timing
- Reset values:
  - state = IDLE.
  - `config_in` = 0 and `config_en` = 0.
  - `busy` = 0, `err` = 0, `frame_count` = 0.
  - `bs_ready` = 1.
- `config_in`, `config_en`, `err`, `frame_count` and `busy` are registered outputs.
- Latency:
  - Final bit accepted at edge N.
  - `config_en` is high during cycle N→N+1.
  - Target loads at edge N+1.
  - `bs_ready` = 1 again from edge N+1.
- Minimum frame period is 1+IDX_W+CFG_WIDTH(+1)+1 cycles. That is 38 cycles with the defaults and no parity.
- Back-to-back frames are allowed. A start bit may be accepted in the cycle right after COMMIT.
- `bs_valid` gaps of any length are allowed mid-frame. Shift position is held across them.
- Reset asserted on the same edge as the final bit: reset wins, no COMMIT, no strobe.

## Configuration
- `CFG_PARITY_EN` defined:
  - PARITY state exists.
  - Each frame carries one trailing bit that makes even parity over index plus payload, so the XOR of index, payload and the trailing bit is 0.
  - Mismatch → no strobe, `err` = 1.
- `CFG_PARITY_EN` undefined:
  - No parity bit and no PARITY state.
  - `err` is set only by an out-of-range index.

## Test plan
- Reset, then 10 zeros with `bs_valid`=1 → `busy`=0, `config_en`=0, `frame_count`=0.
- Frame with idx=3 and payload 33'h1_A5A5_0F0F, `bs_valid` held high:
  - `config_en`=8'b0000_1000 for exactly 1 cycle, 1 cycle after the last bit.
  - `config_in`=33'h1_A5A5_0F0F, held afterwards.
  - `frame_count`=1.
- Same frame with `bs_valid` dropped for 5 cycles after every 4th bit → identical strobe and data, with `bs_ready`=0 only in the COMMIT cycle.
- Back-to-back frames, idx=0 with payload 33'h0_FFFF_0000, then idx=7 with payload 33'h1_0000_FFFF:
  - Two strobes, 8'h01 then 8'h80.
  - `frame_count`=2.
  - `config_in` ends at 33'h1_0000_FFFF.
- Reset asserted at payload bit 20, then a clean idx=1 frame → no strobe before the reset, one strobe 8'h02 after, `err`=0.
- With `CFG_PARITY_EN` and a corrupted parity bit on idx=2:
  - `config_en` stays 0 and `err`=1.
  - `config_in` and `frame_count` are unchanged.
  - A following good frame commits normally and `err` stays 1.

Source files
------------

// File: rtl/cfg_frame_loader.sv
// Serial configuration frame loader: deserializes {start, index, payload[, parity]} and strobes one LUT tile.
// Optional trailing even-parity bit per frame when CFG_PARITY_EN is defined.
module cfg_frame_loader #(
  parameter int unsigned INPUTS      = 4,
  parameter int unsigned CFG_WIDTH   = 2*2**INPUTS+1,
  parameter int unsigned NUM_TARGETS = 8,
  parameter int unsigned IDX_W       = $clog2(NUM_TARGETS),
  parameter int unsigned COUNT_W     = 8
) (
  input  logic                   config_clk,
  input  logic                   config_rst_n,
  input  logic                   bs_data,
  input  logic                   bs_valid,
  output logic                   bs_ready,
  output logic [CFG_WIDTH-1:0]   config_in,
  output logic [NUM_TARGETS-1:0] config_en,
  output logic                   busy,
  output logic                   err,
  output logic [COUNT_W-1:0]     frame_count
);

  localparam int unsigned CNT_W = $clog2(CFG_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INDEX,
    S_PAYLOAD,
    S_PARITY,
    S_COMMIT
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [CFG_WIDTH-1:0] sh;
`ifdef CFG_PARITY_EN
  logic                 par;
`endif

  logic                 accept;
  logic                 idx_ok;
  logic                 commit_go;
  logic                 commit_ok;
  logic [CFG_WIDTH-1:0] sh_next;
  logic [CFG_WIDTH-1:0] commit_data;

  assign bs_ready = (state != S_COMMIT);

  // Detect the final bit of a frame and whether it may be committed.
  always_comb begin
    accept  = bs_valid && bs_ready;
    sh_next = {sh[CFG_WIDTH-2:0], bs_data};
    idx_ok  = (32'(idx) < NUM_TARGETS);
`ifdef CFG_PARITY_EN
    commit_go   = accept && (state == S_PARITY);
    commit_ok   = idx_ok && (par == bs_data);
    commit_data = sh;
`else
    commit_go   = accept && (state == S_PAYLOAD) && (cnt == CNT_W'(CFG_WIDTH - 1));
    commit_ok   = idx_ok;
    commit_data = sh_next;
`endif
  end

  always_ff @(posedge config_clk) begin
    if (!config_rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= '0;
      sh          <= '0;
`ifdef CFG_PARITY_EN
      par         <= 1'b0;
`endif
      config_in   <= '0;
      config_en   <= '0;
      busy        <= 1'b0;
      err         <= 1'b0;
      frame_count <= '0;
    end else begin
      config_en <= '0;
      unique case (state)
        S_IDLE: begin
          if (accept && bs_data) begin
            state <= S_INDEX;
            busy  <= 1'b1;
            cnt   <= '0;
`ifdef CFG_PARITY_EN
            par   <= 1'b0;
`endif
          end
        end
        S_INDEX: begin
          if (accept) begin
            idx <= IDX_W'({idx, bs_data});
`ifdef CFG_PARITY_EN
            par <= par ^ bs_data;
`endif
            if (cnt == CNT_W'(IDX_W - 1)) begin
              cnt   <= '0;
              state <= S_PAYLOAD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_PAYLOAD: begin
          if (accept) begin
            sh <= sh_next;
`ifdef CFG_PARITY_EN
            par <= par ^ bs_data;
`endif
            if (cnt == CNT_W'(CFG_WIDTH - 1)) begin
              cnt <= '0;
`ifdef CFG_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_COMMIT;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
`ifdef CFG_PARITY_EN
        S_PARITY: begin
          if (accept) state <= S_COMMIT;
        end
`endif
        S_COMMIT: begin
          // A non-zero strobe this cycle marks a frame that committed cleanly.
          state <= S_IDLE;
          busy  <= 1'b0;
          if (|config_en) frame_count <= frame_count + 1'b1;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (commit_go) begin
        if (commit_ok) begin
          config_en <= NUM_TARGETS'(1) << idx;
          config_in <= commit_data;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Directed self-checking bench for cfg_frame_loader (default parameters, optional CFG_PARITY_EN).
module tb_cfg_frame_loader;

  localparam int unsigned W  = 33;
  localparam int unsigned NT = 8;
  localparam int unsigned IW = 3;
  localparam int unsigned CW = 8;
`ifdef CFG_PARITY_EN
  localparam int FL = 1 + IW + W + 1;
`else
  localparam int FL = 1 + IW + W;
`endif

  logic          config_clk = 1'b0;
  logic          config_rst_n = 1'b0;
  logic          bs_data = 1'b0;
  logic          bs_valid = 1'b0;
  logic          bs_ready;
  logic [W-1:0]  config_in;
  logic [NT-1:0] config_en;
  logic          busy;
  logic          err;
  logic [CW-1:0] frame_count;

  int n_checks = 0;
  int n_pass = 0;
  int strobe_cnt = 0;
  int ready_low = 0;

  cfg_frame_loader #(
    .INPUTS(4), .CFG_WIDTH(W), .NUM_TARGETS(NT), .IDX_W(IW), .COUNT_W(CW)
  ) dut (
    .config_clk(config_clk), .config_rst_n(config_rst_n),
    .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(bs_ready),
    .config_in(config_in), .config_en(config_en),
    .busy(busy), .err(err), .frame_count(frame_count)
  );

  always #5 config_clk = ~config_clk;

  // Counts strobe cycles and not-ready cycles, sampling pre-edge values.
  always @(posedge config_clk) begin
    if (config_en !== '0) strobe_cnt++;
    if (bs_ready === 1'b0) ready_low++;
  end

  task automatic send_bit(input logic b);
    @(negedge config_clk);
    bs_valid = 1'b1;
    bs_data  = b;
    @(posedge config_clk);
  endtask

  task automatic idle(input int n);
    bs_valid = 1'b0;
    bs_data  = 1'b0;
    repeat (n) @(negedge config_clk);
  endtask

  task automatic send_frame(input logic [IW-1:0] idx, input logic [W-1:0] pl,
                            input bit gaps, input bit bad_par, input int nbits);
    logic fr [0:FL-1];
    fr[0] = 1'b1;
    for (int i = 0; i < int'(IW); i++) fr[1+i] = idx[IW-1-i];
    for (int i = 0; i < int'(W); i++) fr[1+IW+i] = pl[W-1-i];
`ifdef CFG_PARITY_EN
    fr[FL-1] = (^{idx, pl}) ^ bad_par;
`endif
    for (int i = 0; i < nbits; i++) begin
      send_bit(fr[i]);
      if (gaps && (i % 4 == 3) && (i != nbits - 1)) begin
        @(negedge config_clk);
        bs_valid = 1'b0;
        repeat (4) @(negedge config_clk);
      end
    end
  endtask

  task automatic test_reset();
    config_rst_n = 1'b0;
    repeat (3) @(negedge config_clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (config_en !== 8'h00) $display("FAIL rst_en got %h want 00", config_en); else n_pass++;
    n_checks++; if (config_in !== 33'h0) $display("FAIL rst_in got %h want 0", config_in); else n_pass++;
    n_checks++; if (frame_count !== 8'd0) $display("FAIL rst_count got %0d want 0", frame_count); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL rst_err got %b want 0", err); else n_pass++;
    n_checks++; if (bs_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", bs_ready); else n_pass++;
    config_rst_n = 1'b1;
  endtask

  task automatic test_idle_fill();
    int s0 = strobe_cnt;
    for (int i = 0; i < 10; i++) send_bit(1'b0);
    @(negedge config_clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL fill_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (config_en !== 8'h00) $display("FAIL fill_en got %h want 00", config_en); else n_pass++;
    n_checks++; if (frame_count !== 8'd0) $display("FAIL fill_count got %0d want 0", frame_count); else n_pass++;
    n_checks++; if (strobe_cnt - s0 !== 0) $display("FAIL fill_strobes got %0d want 0", strobe_cnt - s0); else n_pass++;
  endtask

  task automatic test_basic();
    int s0 = strobe_cnt;
    send_frame(3'd3, 33'h1_A5A5_0F0F, 1'b0, 1'b0, FL);
    @(negedge config_clk);
    n_checks++; if (config_en !== 8'b0000_1000) $display("FAIL basic_en got %h want 08", config_en); else n_pass++;
    n_checks++; if (config_in !== 33'h1_A5A5_0F0F) $display("FAIL basic_in got %h want 1a5a50f0f", config_in); else n_pass++;
    n_checks++; if (bs_ready !== 1'b0) $display("FAIL basic_ready_commit got %b want 0", bs_ready); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy_commit got %b want 1", busy); else n_pass++;
    bs_data = 1'b0;
    @(negedge config_clk);
    n_checks++; if (config_en !== 8'h00) $display("FAIL basic_en_after got %h want 00", config_en); else n_pass++;
    n_checks++; if (frame_count !== 8'd1) $display("FAIL basic_count got %0d want 1", frame_count); else n_pass++;
    n_checks++; if (config_in !== 33'h1_A5A5_0F0F) $display("FAIL basic_in_hold got %h want 1a5a50f0f", config_in); else n_pass++;
    n_checks++; if (bs_ready !== 1'b1) $display("FAIL basic_ready_after got %b want 1", bs_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_after got %b want 0", busy); else n_pass++;
    n_checks++; if (strobe_cnt - s0 !== 1) $display("FAIL basic_strobes got %0d want 1", strobe_cnt - s0); else n_pass++;
    idle(2);
  endtask

  task automatic test_gaps();
    int s0 = strobe_cnt;
    int r0 = ready_low;
    send_frame(3'd3, 33'h1_A5A5_0F0F, 1'b1, 1'b0, FL);
    @(negedge config_clk);
    n_checks++; if (config_en !== 8'h08) $display("FAIL gap_en got %h want 08", config_en); else n_pass++;
    n_checks++; if (config_in !== 33'h1_A5A5_0F0F) $display("FAIL gap_in got %h want 1a5a50f0f", config_in); else n_pass++;
    n_checks++; if (bs_ready !== 1'b0) $display("FAIL gap_ready_commit got %b want 0", bs_ready); else n_pass++;
    idle(3);
    n_checks++; if (frame_count !== 8'd2) $display("FAIL gap_count got %0d want 2", frame_count); else n_pass++;
    n_checks++; if (strobe_cnt - s0 !== 1) $display("FAIL gap_strobes got %0d want 1", strobe_cnt - s0); else n_pass++;
    n_checks++; if (ready_low - r0 !== 1) $display("FAIL gap_ready_low_cycles got %0d want 1", ready_low - r0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int s0 = strobe_cnt;
    send_frame(3'd0, 33'h0_FFFF_0000, 1'b0, 1'b0, FL);
    @(negedge config_clk);
    n_checks++; if (config_en !== 8'h01) $display("FAIL b2b_en0 got %h want 01", config_en); else n_pass++;
    n_checks++; if (config_in !== 33'h0_FFFF_0000) $display("FAIL b2b_in0 got %h want 0ffff0000", config_in); else n_pass++;
    send_frame(3'd7, 33'h1_0000_FFFF, 1'b0, 1'b0, FL);
    @(negedge config_clk);
    n_checks++; if (config_en !== 8'h80) $display("FAIL b2b_en1 got %h want 80", config_en); else n_pass++;
    idle(2);
    n_checks++; if (config_in !== 33'h1_0000_FFFF) $display("FAIL b2b_in1 got %h want 10000ffff", config_in); else n_pass++;
    n_checks++; if (frame_count !== 8'd4) $display("FAIL b2b_count got %0d want 4", frame_count); else n_pass++;
    n_checks++; if (strobe_cnt - s0 !== 2) $display("FAIL b2b_strobes got %0d want 2", strobe_cnt - s0); else n_pass++;
  endtask

  task automatic test_mid_reset();
    int s0 = strobe_cnt;
    send_frame(3'd4, 33'h1_2222_3333, 1'b0, 1'b0, 1 + IW + 20);
    @(negedge config_clk);
    config_rst_n = 1'b0;
    bs_valid = 1'b0;
    @(negedge config_clk);
    config_rst_n = 1'b1;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (strobe_cnt - s0 !== 0) $display("FAIL midrst_strobes got %0d want 0", strobe_cnt - s0); else n_pass++;
    send_frame(3'd1, 33'h0_1357_9BDF, 1'b0, 1'b0, FL);
    @(negedge config_clk);
    n_checks++; if (config_en !== 8'h02) $display("FAIL midrst_en got %h want 02", config_en); else n_pass++;
    n_checks++; if (config_in !== 33'h0_1357_9BDF) $display("FAIL midrst_in got %h want 013579bdf", config_in); else n_pass++;
    idle(2);
    n_checks++; if (err !== 1'b0) $display("FAIL midrst_err got %b want 0", err); else n_pass++;
    n_checks++; if (frame_count !== 8'd1) $display("FAIL midrst_count got %0d want 1", frame_count); else n_pass++;
    n_checks++; if (strobe_cnt - s0 !== 1) $display("FAIL midrst_strobes_after got %0d want 1", strobe_cnt - s0); else n_pass++;
  endtask

  task automatic test_reset_on_last_bit();
    int s0 = strobe_cnt;
    send_frame(3'd6, 33'h1_FFFF_FFFF, 1'b0, 1'b0, FL - 1);
    @(negedge config_clk);
    bs_valid = 1'b1;
    bs_data  = 1'b1;
    config_rst_n = 1'b0;
    @(negedge config_clk);
    config_rst_n = 1'b1;
    bs_valid = 1'b0;
    n_checks++; if (config_en !== 8'h00) $display("FAIL lastrst_en got %h want 00", config_en); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL lastrst_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (bs_ready !== 1'b1) $display("FAIL lastrst_ready got %b want 1", bs_ready); else n_pass++;
    n_checks++; if (config_in !== 33'h0) $display("FAIL lastrst_in got %h want 0", config_in); else n_pass++;
    idle(2);
    n_checks++; if (frame_count !== 8'd0) $display("FAIL lastrst_count got %0d want 0", frame_count); else n_pass++;
    n_checks++; if (strobe_cnt - s0 !== 0) $display("FAIL lastrst_strobes got %0d want 0", strobe_cnt - s0); else n_pass++;
  endtask

`ifdef CFG_PARITY_EN
  task automatic test_parity();
    int s0 = strobe_cnt;
    send_frame(3'd2, 33'h0_CAFE_F00D, 1'b0, 1'b1, FL);
    @(negedge config_clk);
    n_checks++; if (config_en !== 8'h00) $display("FAIL par_bad_en got %h want 00", config_en); else n_pass++;
    n_checks++; if (err !== 1'b1) $display("FAIL par_bad_err got %b want 1", err); else n_pass++;
    n_checks++; if (bs_ready !== 1'b0) $display("FAIL par_bad_ready got %b want 0", bs_ready); else n_pass++;
    idle(2);
    n_checks++; if (config_in !== 33'h0) $display("FAIL par_bad_in got %h want 0", config_in); else n_pass++;
    n_checks++; if (frame_count !== 8'd0) $display("FAIL par_bad_count got %0d want 0", frame_count); else n_pass++;
    n_checks++; if (strobe_cnt - s0 !== 0) $display("FAIL par_bad_strobes got %0d want 0", strobe_cnt - s0); else n_pass++;
    send_frame(3'd5, 33'h0_1234_5678, 1'b0, 1'b0, FL);
    @(negedge config_clk);
    n_checks++; if (config_en !== 8'h20) $display("FAIL par_good_en got %h want 20", config_en); else n_pass++;
    n_checks++; if (config_in !== 33'h0_1234_5678) $display("FAIL par_good_in got %h want 012345678", config_in); else n_pass++;
    idle(2);
    n_checks++; if (frame_count !== 8'd1) $display("FAIL par_good_count got %0d want 1", frame_count); else n_pass++;
    n_checks++; if (err !== 1'b1) $display("FAIL par_err_sticky got %b want 1", err); else n_pass++;
  endtask
`else
  task automatic test_no_error();
    send_frame(3'd5, 33'h0_1234_5678, 1'b0, 1'b0, FL);
    @(negedge config_clk);
    n_checks++; if (config_en !== 8'h20) $display("FAIL noerr_en got %h want 20", config_en); else n_pass++;
    idle(2);
    n_checks++; if (err !== 1'b0) $display("FAIL noerr_err got %b want 0", err); else n_pass++;
    n_checks++; if (frame_count !== 8'd1) $display("FAIL noerr_count got %0d want 1", frame_count); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_idle_fill();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_mid_reset();
    test_reset_on_last_bit();
`ifdef CFG_PARITY_EN
    test_parity();
`else
    test_no_error();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
